// File: rtl/rom_arbiter.sv
// Two-port arbiter sharing one synchronous single-port ROM; fully pipelined,
// port A preferred, port B guaranteed a grant after MAXWAIT refusals.

module rom_arbiter_ret (
    input  logic       clock,
    input  logic       reset,
    input  logic       cap,
    input  logic [7:0] q,
    output logic       vld,
    output logic [7:0] data
);
    // Per-port return register: data holds between captures.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld  <= 1'b0;
            data <= 8'h00;
        end else begin
            vld <= cap;
            if (cap) data <= q;
        end
    end
endmodule

module rom_arbiter #(
    parameter int AW      = 14,
    parameter int MAXWAIT = 7
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          a_req,
    input  logic [AW-1:0] a_addr,
    output logic          a_ack,
    output logic          a_valid,
    output logic [7:0]    a_data,
    input  logic          b_req,
    input  logic [AW-1:0] b_addr,
    output logic          b_ack,
    output logic          b_valid,
    output logic [7:0]    b_data,
    output logic [AW-1:0] rom_a,
    input  logic [7:0]    rom_q
);
    localparam int NUM_PORTS = 2;
    localparam int STAGES    = 1;
    localparam int WW        = $clog2(MAXWAIT + 1);
    localparam logic [WW-1:0] WMAX = WW'(MAXWAIT);

    logic [WW-1:0]                wcnt;
    logic                         grant_a, grant_b;
    logic [STAGES:0]              vld_pipe;
    logic [STAGES:0]              port_pipe;
    logic [NUM_PORTS-1:0]         rvld;
    logic [NUM_PORTS-1:0][7:0]    rdata;

    // B wins contention only once it has been refused MAXWAIT times.
    always_comb begin
        grant_a = a_req && !(b_req && wcnt == WMAX);
        grant_b = b_req && !grant_a;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wcnt      <= '0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            rom_a     <= '0;
            vld_pipe  <= '0;
            port_pipe <= '0;
        end else begin
            a_ack     <= grant_a;
            b_ack     <= grant_b;
            vld_pipe  <= {vld_pipe[STAGES-1:0], grant_a | grant_b};
            port_pipe <= {port_pipe[STAGES-1:0], grant_b};
            if (grant_a)      rom_a <= a_addr;
            else if (grant_b) rom_a <= b_addr;
            if (grant_b)
                wcnt <= '0;
            else if (b_req && grant_a && wcnt != WMAX)
                wcnt <= wcnt + 1'b1;
        end
    end

    // Stage index 0 is the port A return path, 1 is port B.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_ret
        rom_arbiter_ret u_ret (
            .clock (clock),
            .reset (reset),
            .cap   (vld_pipe[STAGES] && (port_pipe[STAGES] == 1'(p))),
            .q     (rom_q),
            .vld   (rvld[p]),
            .data  (rdata[p])
        );
    end

    assign a_valid = rvld[0];
    assign a_data  = rdata[0];
    assign b_valid = rvld[1];
    assign b_data  = rdata[1];
endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: behavioural ROM with mem[i]=i[7:0],
// inputs driven and outputs checked on the falling edge.

module tb_rom_arbiter;
    localparam int AW = 14;
    localparam int MAXWAIT = 7;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          a_req = 1'b0, b_req = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic          a_ack, a_valid, b_ack, b_valid;
    logic [7:0]    a_data, b_data, rom_q;
    logic [AW-1:0] rom_a;
    logic [7:0]    mem [0:(1<<AW)-1];

    int n_cmp = 0, n_err = 0, both_cnt = 0;
    logic [7:0] aq[$], bq[$];

    rom_arbiter #(.AW(AW), .MAXWAIT(MAXWAIT)) dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_valid(a_valid), .a_data(a_data),
        .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack), .b_valid(b_valid), .b_data(b_data),
        .rom_a(rom_a), .rom_q(rom_q)
    );

    always #5 clock = ~clock;

    always @(posedge clock) rom_q <= mem[rom_a];

    always @(negedge clock) begin
        if (a_valid) aq.push_back(a_data);
        if (b_valid) bq.push_back(b_data);
        if (a_valid && b_valid) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic nedge();
        @(negedge clock);
    endtask

    initial begin
        int na, nb;
        logic [7:0] alt_d [4];
        logic       alt_b [4];
        for (int i = 0; i < (1<<AW); i++) mem[i] = i[7:0];

        // Reset state
        repeat (3) nedge();
        chk("rst_a_ack", a_ack, 0);
        chk("rst_b_ack", b_ack, 0);
        chk("rst_valids", {a_valid, b_valid}, 0);
        chk("rst_data", {a_data, b_data}, 0);
        chk("rst_rom_a", rom_a, 0);
        reset = 1'b0;

        // Single A read at 0x0123
        nedge(); a_req = 1; a_addr = 14'h0123;
        nedge(); chk("single_ack", a_ack, 1); chk("single_rom_a", rom_a, 14'h0123); a_req = 0;
        nedge(); chk("single_ack_off", a_ack, 0); chk("single_early", a_valid, 0);
        nedge(); chk("single_valid", a_valid, 1); chk("single_data", a_data, 8'h23);
        chk("single_no_b", b_valid, 0);
        nedge(); chk("single_valid_off", a_valid, 0); chk("single_hold", a_data, 8'h23);

        // Back-to-back A burst 0x10..0x17
        a_req = 1; a_addr = 14'h0010;
        for (int i = 0; i < 8; i++) begin
            nedge();
            chk("burst_ack", a_ack, 1);
            if (i >= 2) begin
                chk("burst_valid", a_valid, 1);
                chk("burst_data", a_data, 8'h10 + 8'(i - 2));
            end
            if (i < 7) a_addr = 14'h0011 + 14'(i); else a_req = 0;
        end
        for (int i = 6; i < 8; i++) begin
            nedge();
            chk("burst_valid", a_valid, 1);
            chk("burst_data", a_data, 8'h10 + 8'(i));
        end
        nedge(); chk("burst_end", a_valid, 0);

        // Contention: seven A grants, then one B grant, repeating
        aq.delete(); bq.delete();
        na = 0; nb = 0;
        a_req = 1; b_req = 1; a_addr = 14'h0200; b_addr = 14'h1300;
        for (int i = 0; i < 24; i++) begin
            nedge();
            chk("cont_a_ack", a_ack, (i % 8) != 7);
            chk("cont_b_ack", b_ack, (i % 8) == 7);
            if (a_ack) na++;
            if (b_ack) nb++;
            a_addr = 14'h0200 + 14'(na);
            b_addr = 14'h1300 + 14'(nb);
            if (i == 23) begin a_req = 0; b_req = 0; end
        end
        repeat (4) nedge();
        chk("cont_a_cnt", aq.size(), 21);
        chk("cont_b_cnt", bq.size(), 3);
        for (int k = 0; k < 21 && k < aq.size(); k++) chk("cont_a_data", aq[k], 8'(k));
        for (int k = 0; k < 3 && k < bq.size(); k++) chk("cont_b_data", bq[k], 8'(k));

        // Port B alone at the top address
        b_req = 1; b_addr = 14'h3FFF;
        nedge(); chk("b_ack", b_ack, 1); chk("b_no_a_ack", a_ack, 0); b_req = 0;
        nedge();
        nedge(); chk("b_valid", b_valid, 1); chk("b_data", b_data, 8'hFF);
        chk("b_a_hold", a_data, 8'h14); chk("b_no_a_valid", a_valid, 0);

        // Alternating A, B, A, B on successive edges
        alt_d = '{8'h41, 8'h52, 8'h63, 8'h74};
        alt_b = '{1'b0, 1'b1, 1'b0, 1'b1};
        a_req = 1; a_addr = 14'h0041;
        for (int i = 1; i <= 6; i++) begin
            nedge();
            if (i <= 4) begin
                chk("alt_a_ack", a_ack, !alt_b[i-1]);
                chk("alt_b_ack", b_ack, alt_b[i-1]);
            end
            if (i >= 3) begin
                chk("alt_a_valid", a_valid, !alt_b[i-3]);
                chk("alt_b_valid", b_valid, alt_b[i-3]);
                chk("alt_data", alt_b[i-3] ? b_data : a_data, alt_d[i-3]);
            end
            case (i)
                1: begin a_req = 0; b_req = 1; b_addr = 14'h0052; end
                2: begin b_req = 0; a_req = 1; a_addr = 14'h0063; end
                3: begin a_req = 0; b_req = 1; b_addr = 14'h0074; end
                default: begin a_req = 0; b_req = 0; end
            endcase
        end

        // Reset with two A accesses in flight
        nedge(); a_req = 1; a_addr = 14'h0100;
        nedge(); chk("rm_ack0", a_ack, 1); a_addr = 14'h0101;
        nedge(); chk("rm_ack1", a_ack, 1); a_req = 0;
        reset = 1;
        #1;
        chk("rm_acks", {a_ack, b_ack}, 0);
        chk("rm_valids", {a_valid, b_valid}, 0);
        chk("rm_data", {a_data, b_data}, 0);
        chk("rm_rom_a", rom_a, 0);
        nedge(); chk("rm_in_reset", a_valid, 0); reset = 0;
        nedge(); chk("rm_discard", {a_valid, b_valid}, 0); a_req = 1; a_addr = 14'h0155;
        nedge(); chk("rm_new_ack", a_ack, 1); chk("rm_discard2", a_valid, 0); a_req = 0;
        nedge(); chk("rm_early", a_valid, 0);
        nedge(); chk("rm_new_valid", a_valid, 1); chk("rm_new_data", a_data, 8'h55);

        chk("never_both_valid", both_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Shares one synchronous single-port ROM (one-cycle registered read, address sampled on the rising clock edge) between two requesters: port A (CPU side, normally preferred) and port B (loader/DMA side). Runs fully pipelined, so it can accept one access per clock. Returns read data to the correct requester two clocks after acceptance. A wait counter guarantees that port B is never starved.

## Interface
Parameters:
- AW, 14, ROM address width in bits (14 = 16 KB).
- MAXWAIT, 7, maximum number of consecutive cycles port B may be refused while requesting; must be ≥1.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- a_req  in  1  port A request; a_addr must be stable while a_req is high.
- a_addr  in  AW  port A byte address.
- a_ack  out  1  one-cycle pulse: the port A request sampled at the previous edge was accepted.
- a_valid  out  1  one-cycle pulse: a_data holds the byte for the oldest outstanding port A access.
- a_data  out  8  port A read data; holds its value between valids.
- b_req, b_addr, b_ack, b_valid, b_data  same as port A, for port B.
- rom_a  out  AW  address to the ROM; registered.
- rom_q  in  8  ROM data; valid one clock after rom_a is sampled.

## Operation
- Arbitration is evaluated at every edge from the sampled a_req and b_req:
  - Only one port requesting: that port is granted.
  - Both requesting and wcnt < MAXWAIT: A is granted.
  - Both requesting and wcnt == MAXWAIT: B is granted.
  - Neither requesting: idle; rom_a holds its last value.
- Grant at edge N:
  - rom_a is loaded with the winner's address.
  - The winner's ack is high for the cycle after N.
  - Tag stage 1 is loaded with {valid=1, port}.
- The ack protocol is registered. A requester that still has a_req/b_req high at edge N+1 issues a new request at N+1, with whatever address it presents then. Back-to-back accepted requests at full rate are legal.
- wcnt is a saturating counter of width $clog2(MAXWAIT+1):
  - Cleared on reset and on any B grant.
  - Incremented at each edge where b_req is high and A is granted.
  - Unchanged when b_req is low.
- Pipeline:
  - Tag stage 1 advances to tag stage 2 every edge.
  - At the edge where tag stage 2 is valid, rom_q is captured into the tagged port's data register, and that port's valid is high for the following cycle.
  - The other port's data register is untouched.
  - An idle edge loads tag stage 1 with valid=0.
- Data is always returned in grant order per port. No reordering is possible because there is a single pipeline.
- Requests are never dropped. A refused request simply stays pending until the requester sees ack.

## Timing
- Latency: request sampled at edge N → ack in cycle N..N+1 → rom_a valid from edge N → ROM samples at N+1 → data captured at edge N+2 → valid high in cycle N+2..N+3.
- Throughput: one access per clock, shared between the ports.
- Worst-case port B wait: MAXWAIT refused cycles, then a guaranteed grant at the next edge.
- Reset values: a_ack=0, b_ack=0, a_valid=0, b_valid=0, a_data=8'h00, b_data=8'h00, rom_a=0, wcnt=0, both tag stages invalid.
- Reset mid-operation: in-flight accesses are discarded and no valid is issued for them. The first grant after reset release occurs at the first edge with reset low.
- ack and valid for the same port may be high in the same cycle, for different accesses.
- Simultaneous a_valid and b_valid never occurs.

## Test plan
- Single A read: ROM preloaded with mem[i] = i[7:0]; a_req high for one accepted access at a_addr=0x0123 → a_ack one cycle later, a_valid two cycles after that, a_data=0x23; no b_valid.
- Back-to-back A burst: a_req held high, a_addr stepping 0x0010..0x0017 each cycle after ack → eight acks, then eight consecutive a_valid cycles with data 0x10..0x17 in order.
- Contention, MAXWAIT=7: both requests held high continuously → pattern of seven A grants then one B grant, repeating; wcnt returns to 0 after each B grant; every returned byte matches its address.
- Port B alone: b_req high at b_addr=0x3FFF (top address, AW=14) → b_ack, then b_valid with mem[0x3FFF]=0xFF; a_data stays at its previous value.
- Alternating requests: a_req and b_req toggled so that A, B, A, B are each accepted on successive edges → a_valid and b_valid alternate, never high together, each with correct data.
- Reset mid-burst: assert reset while two accesses are in flight → all outputs reach reset values immediately; no valid appears for the discarded accesses; a new A request after release completes with normal latency.
